// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial sequence detector.
package seq_det_pkg;

   localparam int PAT_W_MAX = 32;
   localparam int CNT_W_DEF = 8;

   // Enough bits to hold every value from 0 to pat_w.
   function automatic int fill_width(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

   // Shadow configuration. Pattern and mask are zero-extended to the maximum width.
   typedef struct packed {
      logic [PAT_W_MAX-1:0] pattern;
      logic [PAT_W_MAX-1:0] mask;
      logic                 overlap;
   } cfg_t;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Generic up-counter with synchronous clear that saturates at MAX instead of wrapping.
module seq_det_sat_cnt #(
   parameter int           W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Clear takes priority over increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt < MAX)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/seq_det_prog.sv
// Serial sequence detector with a runtime pattern, don't-care mask and overlap mode.
// Define SEQ_DET_STICKY_EN to add the det_clr input and the sticky det_flag output.
module seq_det_prog
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 12,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x_vld,
   input  logic             x_in,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [PAT_W-1:0] cfg_mask,
   input  logic             cfg_overlap,
`ifdef SEQ_DET_STICKY_EN
   input  logic             det_clr,
   output logic             det_flag,
`endif
   output logic             det_out,
   output logic [CNT_W-1:0] det_cnt,
   output logic             fill_ok
);

   localparam int                FILL_W   = fill_width(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(PAT_W - 1);

   cfg_t                 cfg_q;
   cfg_t                 cfg_in;
   logic [PAT_W-1:0]     shift_q;
   logic [PAT_W-1:0]     nxt_shift;
   logic [PAT_W_MAX-1:0] window;
   logic [FILL_W-1:0]    fill;
   logic                 sample;
   logic                 hit;
   logic                 fill_clr;
   logic                 fill_ok_nxt;

   // A load cycle swallows any bit presented alongside it.
   always_comb begin
      cfg_in                    = '0;
      cfg_in.pattern[PAT_W-1:0] = cfg_pattern;
      cfg_in.mask[PAT_W-1:0]    = cfg_mask;
      cfg_in.overlap            = cfg_overlap;
      sample                    = x_vld & ~cfg_load;
      nxt_shift                 = {shift_q[PAT_W-2:0], x_in};
      window                    = '0;
      window[PAT_W-1:0]         = nxt_shift;
      hit = sample && (fill >= FILL_PRE)
            && (((window ^ cfg_q.pattern) & cfg_q.mask) == '0);
      fill_clr = cfg_load | (hit & ~cfg_q.overlap);
      fill_ok_nxt = fill_ok;
      if (fill_clr) begin
         fill_ok_nxt = 1'b0;
      end else if (sample) begin
         fill_ok_nxt = (fill >= FILL_PRE);
      end
   end

   seq_det_sat_cnt #(
      .W   (FILL_W),
      .MAX (FILL_MAX)
   ) u_fill_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (fill_clr),
      .inc   (sample),
      .cnt   (fill)
   );

   seq_det_sat_cnt #(
      .W (CNT_W)
   ) u_det_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cfg_load),
      .inc   (hit),
      .cnt   (det_cnt)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_q   <= '0;
         shift_q <= '0;
         det_out <= 1'b0;
         fill_ok <= 1'b0;
      end else begin
         det_out <= hit;
         fill_ok <= fill_ok_nxt;
         if (cfg_load) begin
            cfg_q   <= cfg_in;
            shift_q <= '0;
         end else if (sample) begin
            shift_q <= nxt_shift;
         end
      end
   end

`ifdef SEQ_DET_STICKY_EN
   // A new match beats a simultaneous clear; a reload always clears.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         det_flag <= 1'b0;
      end else if (cfg_load) begin
         det_flag <= 1'b0;
      end else if (hit) begin
         det_flag <= 1'b1;
      end else if (det_clr) begin
         det_flag <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: a 12-bit/8-bit and a 4-bit/2-bit instance share one bit stream.
// Checks the sticky flag as well when SEQ_DET_STICKY_EN is defined.
module tb_seq_det_prog;

   logic        clk;
   logic        reset;
   logic        x_vld;
   logic        x_in;
   logic        cfg_load;
   logic        cfg_overlap;
   logic        det_clr;
   logic [11:0] pat_a;
   logic [11:0] mask_a;
   logic [3:0]  pat_b;
   logic [3:0]  mask_b;
   logic        det_a;
   logic        det_b;
   logic [7:0]  cnt_a;
   logic [1:0]  cnt_b;
   logic        fok_a;
   logic        fok_b;
`ifdef SEQ_DET_STICKY_EN
   logic        flag_a;
   logic        flag_b;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   seq_det_prog #(.PAT_W(12), .CNT_W(8)) u_dut_a (
      .clk         (clk),
      .reset       (reset),
      .x_vld       (x_vld),
      .x_in        (x_in),
      .cfg_load    (cfg_load),
      .cfg_pattern (pat_a),
      .cfg_mask    (mask_a),
      .cfg_overlap (cfg_overlap),
`ifdef SEQ_DET_STICKY_EN
      .det_clr     (det_clr),
      .det_flag    (flag_a),
`endif
      .det_out     (det_a),
      .det_cnt     (cnt_a),
      .fill_ok     (fok_a)
   );

   seq_det_prog #(.PAT_W(4), .CNT_W(2)) u_dut_b (
      .clk         (clk),
      .reset       (reset),
      .x_vld       (x_vld),
      .x_in        (x_in),
      .cfg_load    (cfg_load),
      .cfg_pattern (pat_b),
      .cfg_mask    (mask_b),
      .cfg_overlap (cfg_overlap),
`ifdef SEQ_DET_STICKY_EN
      .det_clr     (det_clr),
      .det_flag    (flag_b),
`endif
      .det_out     (det_b),
      .det_cnt     (cnt_b),
      .fill_ok     (fok_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: index 0 tracks the 12-bit instance, index 1 the 4-bit one.
   int          pw   [2] = '{12, 4};
   int          cmax [2] = '{255, 3};
   bit          hist [2][$];
   logic [31:0] m_pat  [2] = '{32'd0, 32'd0};
   logic [31:0] m_mask [2] = '{32'd0, 32'd0};
   bit          m_ovl  [2] = '{1'b0, 1'b0};
   int          m_cnt  [2] = '{0, 0};
   bit          m_det  [2] = '{1'b0, 1'b0};
   bit          m_fok  [2] = '{1'b0, 1'b0};
   bit          m_flag [2] = '{1'b0, 1'b0};

   function automatic bit window_hit(input int d);
      if (hist[d].size() != pw[d]) return 1'b0;
      for (int i = 0; i < pw[d]; i++) begin
         int pos;
         pos = pw[d] - 1 - i;
         if (m_mask[d][pos] && (hist[d][i] != m_pat[d][pos])) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(negedge reset) begin
      for (int d = 0; d < 2; d++) begin
         hist[d].delete();
         m_pat[d]  = '0;
         m_mask[d] = '0;
         m_ovl[d]  = 1'b0;
         m_cnt[d]  = 0;
         m_det[d]  = 1'b0;
         m_fok[d]  = 1'b0;
         m_flag[d] = 1'b0;
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            bit hit_now;
            hit_now = 1'b0;
            if (cfg_load) begin
               m_pat[d]  = (d == 0) ? 32'(pat_a) : 32'(pat_b);
               m_mask[d] = (d == 0) ? 32'(mask_a) : 32'(mask_b);
               m_ovl[d]  = cfg_overlap;
               m_cnt[d]  = 0;
               m_flag[d] = 1'b0;
               hist[d].delete();
            end else if (x_vld) begin
               hist[d].push_back(x_in);
               if (hist[d].size() > pw[d]) void'(hist[d].pop_front());
               hit_now = window_hit(d);
               if (hit_now) begin
                  if (m_cnt[d] < cmax[d]) m_cnt[d] = m_cnt[d] + 1;
                  if (!m_ovl[d]) hist[d].delete();
               end
            end
            if (!cfg_load) begin
               if (hit_now) m_flag[d] = 1'b1;
               else if (det_clr) m_flag[d] = 1'b0;
            end
            m_det[d] = hit_now;
            m_fok[d] = (hist[d].size() == pw[d]);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         checkOutput("det_out_a", 32'(det_a), 32'(m_det[0]));
         checkOutput("det_cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
         checkOutput("fill_ok_a", 32'(fok_a), 32'(m_fok[0]));
         checkOutput("det_out_b", 32'(det_b), 32'(m_det[1]));
         checkOutput("det_cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
         checkOutput("fill_ok_b", 32'(fok_b), 32'(m_fok[1]));
`ifdef SEQ_DET_STICKY_EN
         checkOutput("det_flag_a", 32'(flag_a), 32'(m_flag[0]));
         checkOutput("det_flag_b", 32'(flag_b), 32'(m_flag[1]));
`endif
      end
   end

   // One clock cycle of input; returns 1 time unit after the edge.
   task automatic applyStimulus(input bit vld, input bit b, input bit load, input bit clr);
      x_vld    = vld;
      x_in     = b;
      cfg_load = load;
      det_clr  = clr;
      @(posedge clk);
      #1;
      x_vld    = 1'b0;
      cfg_load = 1'b0;
      det_clr  = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, v[i], 1'b0, 1'b0);
   endtask

   task automatic do_cfg(input logic [11:0] pa, input logic [11:0] ma,
                         input logic [3:0] pb, input logic [3:0] mb, input bit ovl);
      pat_a       = pa;
      mask_a      = ma;
      pat_b       = pb;
      mask_b      = mb;
      cfg_overlap = ovl;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [31:0] v;
      logic [3:0]  nib;
      int          flip_pos [3] = '{11, 8, 0};
      int          exp_b    [5] = '{1, 2, 3, 3, 3};

      reset = 1'b0;
      x_vld = 1'b0; x_in = 1'b0; cfg_load = 1'b0; det_clr = 1'b0;
      cfg_overlap = 1'b0; pat_a = '0; mask_a = '0; pat_b = '0; mask_b = '0;
      #2;
      checkOutput("rst_det_a", 32'(det_a), 32'd0);
      checkOutput("rst_cnt_a", 32'(cnt_a), 32'd0);
      checkOutput("rst_fok_a", 32'(fok_a), 32'd0);
      checkOutput("rst_cnt_b", 32'(cnt_b), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      $display("[TB] full 12-bit pattern, overlap on");
      do_cfg(12'hEDB, 12'hFFF, 4'hA, 4'hF, 1'b1);
      send_bits(32'hEDB >> 1, 11);
      checkOutput("t1_det_early", 32'(det_a), 32'd0);
      checkOutput("t1_fok_early", 32'(fok_a), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("t1_det", 32'(det_a), 32'd1);
      checkOutput("t1_cnt", 32'(cnt_a), 32'd1);
      checkOutput("t1_fok", 32'(fok_a), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_det_pulse", 32'(det_a), 32'd0);

      $display("[TB] 4-bit pattern, overlap on then off");
      do_cfg(12'hEDB, 12'hFFF, 4'hA, 4'hF, 1'b1);
      send_bits(32'b101010, 6);
      checkOutput("t2_ovl_cnt", 32'(cnt_b), 32'd2);
      checkOutput("t2_ovl_det", 32'(det_b), 32'd1);
      do_cfg(12'hEDB, 12'hFFF, 4'hA, 4'hF, 1'b0);
      send_bits(32'b101010, 6);
      checkOutput("t2_novl_cnt", 32'(cnt_b), 32'd1);
      checkOutput("t2_novl_det", 32'(det_b), 32'd0);
      checkOutput("t2_novl_fok", 32'(fok_b), 32'd0);

      $display("[TB] masked middle nibble");
      do_cfg(12'hE0B, 12'hF0F, 4'hA, 4'hF, 1'b0);
      for (int t = 0; t < 4; t++) begin
         nib = 4'($urandom_range(0, 15));
         send_bits({20'd0, 4'hE, nib, 4'hB}, 12);
         checkOutput("t3_hit", 32'(det_a), 32'd1);
      end
      checkOutput("t3_cnt", 32'(cnt_a), 32'd4);
      for (int t = 0; t < 3; t++) begin
         nib = 4'($urandom_range(0, 15));
         v = {20'd0, 4'hE, nib, 4'hB} ^ (32'd1 << flip_pos[t]);
         send_bits(v, 12);
         checkOutput("t3_flip", 32'(det_a), 32'd0);
      end

      $display("[TB] valid gaps and mid-pattern reload");
      do_cfg(12'hEDB, 12'hFFF, 4'hA, 4'hF, 1'b0);
      v = 32'hEDB;
      for (int i = 11; i >= 0; i--) begin
         applyStimulus(1'b1, v[i], 1'b0, 1'b0);
         if (i != 0)
            for (int g = 0; g <= (i % 5); g++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("t4_gap_det", 32'(det_a), 32'd1);
      checkOutput("t4_gap_cnt", 32'(cnt_a), 32'd1);
      send_bits(32'hEDB >> 6, 6);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      send_bits(32'hEDB & 32'h3F, 6);
      checkOutput("t4_reload_det", 32'(det_a), 32'd0);
      checkOutput("t4_reload_cnt", 32'(cnt_a), 32'd0);
      send_bits(32'hEDB, 12);
      checkOutput("t4_fresh_det", 32'(det_a), 32'd1);
      checkOutput("t4_fresh_cnt", 32'(cnt_a), 32'd1);

      $display("[TB] small counter saturation and async reset");
      do_cfg(12'hEDB, 12'hFFF, 4'hA, 4'hF, 1'b1);
      send_bits(32'b10, 2);
      for (int k = 0; k < 5; k++) begin
         send_bits(32'b10, 2);
         checkOutput("t5_sat_cnt", 32'(cnt_b), 32'(exp_b[k]));
      end
      #2 reset = 1'b0;
      #1;
      checkOutput("t5_arst_det_b", 32'(det_b), 32'd0);
      checkOutput("t5_arst_cnt_b", 32'(cnt_b), 32'd0);
      checkOutput("t5_arst_fok_b", 32'(fok_b), 32'd0);
      checkOutput("t5_arst_cnt_a", 32'(cnt_a), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      send_bits(32'd0, 12);
      checkOutput("t5_mask0_det_a", 32'(det_a), 32'd1);
      checkOutput("t5_mask0_cnt_a", 32'(cnt_a), 32'd1);
      checkOutput("t5_mask0_cnt_b", 32'(cnt_b), 32'd3);

`ifdef SEQ_DET_STICKY_EN
      $display("[TB] sticky flag");
      do_cfg(12'hEDB, 12'hFFF, 4'hA, 4'hF, 1'b1);
      send_bits(32'hEDB, 12);
      checkOutput("t6_flag_set", 32'(flag_a), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("t6_flag_clr", 32'(flag_a), 32'd0);
      send_bits(32'hEDB >> 1, 11);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("t6_set_wins", 32'(flag_a), 32'd1);
      do_cfg(12'hEDB, 12'hFFF, 4'hA, 4'hF, 1'b1);
      checkOutput("t6_load_clr", 32'(flag_a), 32'd0);
`endif

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
